// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/mem pipeline ports, the arbiter and the single-port Memory.
// slave = arbiter side; master = requesters plus Memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_valid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_valid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata,
    output mem_ren, mem_wen, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_valid, i_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port Memory between the I (fetch, read-only) and D ports via IDLE/ACCESS/RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build gives D fixed priority.
module mem_port_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  mem_port_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] conflicts
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t           state_q,   state_d;
  owner_t           owner_q,   owner_d;
  logic             we_q,      we_d;
  logic [AW-1:0]    addr_q,    addr_d;
  logic [DW-1:0]    wdata_q,   wdata_d;
  logic [DW-1:0]    i_rdata_q, i_rdata_d;
  logic [DW-1:0]    d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic arb_en;
  logic both_req;
  logic any_req;
  logic d_wins;
  logic in_access;
  logic in_resp;

  assign arb_en   = (state_q == IDLE) || (state_q == RESP);
  assign both_req = bus.i_req & bus.d_req;
  assign any_req  = bus.i_req | bus.d_req;

  // owner_q doubles as the last-served register; it resets to I so D takes the first tie.
`ifdef ARB_ROUND_ROBIN_EN
  assign d_wins = both_req ? (owner_q == OWN_I) : bus.d_req;
`else
  assign d_wins = bus.d_req;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d = ACCESS;
          if (d_wins) begin
            owner_d = OWN_D;
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_we ? bus.d_wdata : '0;
          end else begin
            owner_d = OWN_I;
            addr_d  = bus.i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (owner_q == OWN_I) begin
          i_rdata_d = bus.mem_dout;
        end else begin
          d_rdata_d = we_q ? '0 : bus.mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase

    if (arb_en && both_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign bus.i_gnt   = in_access && (owner_q == OWN_I);
  assign bus.d_gnt   = in_access && (owner_q == OWN_D);
  assign bus.i_valid = in_resp   && (owner_q == OWN_I);
  assign bus.d_valid = in_resp   && (owner_q == OWN_D);
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  // Memory strobes are decoded from state so they can never overlap or leak outside ACCESS.
  assign bus.mem_ren  = in_access & ~we_q;
  assign bus.mem_wen  = in_access &  we_q;
  assign bus.mem_addr = in_access ? addr_q  : '0;
  assign bus.mem_din  = in_access ? wdata_q : '0;

  assign busy      = (state_q != IDLE);
  assign conflicts = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port Memory (write on negedge).
// Compile with +define+ARB_ROUND_ROBIN_EN to exercise the round-robin build.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] conflicts;

  int vectors     = 0;
  int miscompares = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .conflicts (conflicts)
  );

  always #5 clock = ~clock;

  // Memory: unwritten words read back a fixed address-derived pattern.
  logic [DW-1:0] mem     [16];
  logic [15:0]   written = '0;

  function automatic logic [DW-1:0] seed(input int unsigned a);
    return 32'h1000_0000 | (a * 32'h11);
  endfunction

  always @(negedge clock) begin
    if (reset && bus.mem_wen) begin
      mem[bus.mem_addr[3:0]]     <= bus.mem_din;
      written[bus.mem_addr[3:0]] <= 1'b1;
    end
  end

  assign bus.mem_dout = !bus.mem_ren ? '0 :
                        (written[bus.mem_addr[3:0]] ? mem[bus.mem_addr[3:0]]
                                                    : seed(int'(bus.mem_addr[3:0])));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'd2;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd4; bus.d_wdata = 32'h1234;
    step();
    step();
    vectors++;
    if ({bus.i_gnt, bus.i_valid, bus.d_gnt, bus.d_valid, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_strobes got=%b exp=00000", {bus.i_gnt, bus.i_valid, bus.d_gnt, bus.d_valid, busy});
    end
    vectors++;
    if ({bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_din} !== '0) begin
      miscompares++;
      $display("FAIL rst_mem got ren=%b wen=%b addr=%h din=%h exp all 0",
               bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_din);
    end
    vectors++;
    if ({bus.i_rdata, bus.d_rdata, conflicts} !== '0) begin
      miscompares++;
      $display("FAIL rst_data got i_rdata=%h d_rdata=%h conflicts=%0d exp 0",
               bus.i_rdata, bus.d_rdata, conflicts);
    end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    apply_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd1;
    step();
    bus.d_req = 1'b0;
    step();
    vectors++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== seed(1)) begin
      miscompares++;
      $display("FAIL dread_resp got valid=%b rdata=%h exp valid=1 rdata=%h", bus.d_valid, bus.d_rdata, seed(1));
    end
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd5; bus.d_wdata = 32'hCAFE;
    step();
    vectors++;
    if ({bus.d_gnt, bus.i_gnt, bus.mem_wen, bus.mem_ren, busy} !== 5'b10101) begin
      miscompares++;
      $display("FAIL wr_access got gnt_d/gnt_i/wen/ren/busy=%b exp=10101",
               {bus.d_gnt, bus.i_gnt, bus.mem_wen, bus.mem_ren, busy});
    end
    vectors++;
    if (bus.mem_addr !== 32'd5 || bus.mem_din !== 32'hCAFE) begin
      miscompares++;
      $display("FAIL wr_bus got addr=%h din=%h exp addr=5 din=cafe", bus.mem_addr, bus.mem_din);
    end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    step();
    vectors++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.mem_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_resp got valid=%b rdata=%h wen=%b exp valid=1 rdata=0 wen=0",
               bus.d_valid, bus.d_rdata, bus.mem_wen);
    end
    bus.i_req = 1'b1; bus.i_addr = 32'd5;
    step();
    vectors++;
    if (bus.i_gnt !== 1'b1 || bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_addr !== 32'd5) begin
      miscompares++;
      $display("FAIL ird_access got gnt=%b ren=%b wen=%b addr=%h exp 1 1 0 5",
               bus.i_gnt, bus.mem_ren, bus.mem_wen, bus.mem_addr);
    end
    bus.i_req = 1'b0;
    step();
    vectors++;
    if (bus.i_valid !== 1'b1 || bus.i_rdata !== 32'hCAFE) begin
      miscompares++;
      $display("FAIL ird_resp got valid=%b rdata=%h exp valid=1 rdata=cafe", bus.i_valid, bus.i_rdata);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || bus.i_valid !== 1'b0 || bus.i_rdata !== 32'hCAFE) begin
      miscompares++;
      $display("FAIL ird_hold got busy=%b valid=%b rdata=%h exp 0 0 cafe", busy, bus.i_valid, bus.i_rdata);
    end
  endtask

  task automatic test_both_requests();
    apply_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd1;
    bus.i_req = 1'b1; bus.i_addr = 32'd2;
    step();
    vectors++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL tie1_gnt got d/i=%b exp=10", {bus.d_gnt, bus.i_gnt});
    end
    step();
    vectors++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== seed(1)) begin
      miscompares++;
      $display("FAIL tie1_resp got valid=%b rdata=%h exp 1 %h", bus.d_valid, bus.d_rdata, seed(1));
    end
    step();
`ifdef ARB_ROUND_ROBIN_EN
    vectors++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_gnt2 got d/i=%b exp=01", {bus.d_gnt, bus.i_gnt});
    end
    step();
    vectors++;
    if ({bus.i_valid, bus.d_valid} !== 2'b10 || bus.i_rdata !== seed(2)) begin
      miscompares++;
      $display("FAIL rr_resp2 got i/d valid=%b rdata=%h exp 10 %h", {bus.i_valid, bus.d_valid}, bus.i_rdata, seed(2));
    end
    step();
    vectors++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10 || conflicts !== 2'd3) begin
      miscompares++;
      $display("FAIL rr_gnt3 got d/i=%b conflicts=%0d exp 10 3", {bus.d_gnt, bus.i_gnt}, conflicts);
    end
    idle_inputs();
    step();
    vectors++;
    if ({bus.i_valid, bus.d_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL rr_resp3 got i/d valid=%b exp=01", {bus.i_valid, bus.d_valid});
    end
`else
    vectors++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10 || conflicts !== 2'd2) begin
      miscompares++;
      $display("FAIL fp_starve got d/i=%b conflicts=%0d exp 10 2", {bus.d_gnt, bus.i_gnt}, conflicts);
    end
    bus.d_req = 1'b0;
    step();
    vectors++;
    if ({bus.i_valid, bus.d_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL fp_resp2 got i/d valid=%b exp=01", {bus.i_valid, bus.d_valid});
    end
    step();
    vectors++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b01 || conflicts !== 2'd2) begin
      miscompares++;
      $display("FAIL fp_igrant got d/i=%b conflicts=%0d exp 01 2", {bus.d_gnt, bus.i_gnt}, conflicts);
    end
    idle_inputs();
    step();
    vectors++;
    if (bus.i_valid !== 1'b1 || bus.i_rdata !== seed(2)) begin
      miscompares++;
      $display("FAIL fp_iresp got valid=%b rdata=%h exp 1 %h", bus.i_valid, bus.i_rdata, seed(2));
    end
`endif
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'd3;
    step();
    vectors++;
    if ({bus.i_gnt, bus.mem_ren, bus.mem_wen} !== 3'b110) begin
      miscompares++;
      $display("FAIL b2b_acc1 got gnt/ren/wen=%b exp=110", {bus.i_gnt, bus.mem_ren, bus.mem_wen});
    end
    step();
    vectors++;
    if ({bus.i_valid, bus.mem_ren, bus.mem_wen} !== 3'b100 || bus.i_rdata !== seed(3)) begin
      miscompares++;
      $display("FAIL b2b_resp1 got valid/ren/wen=%b rdata=%h exp 100 %h",
               {bus.i_valid, bus.mem_ren, bus.mem_wen}, bus.i_rdata, seed(3));
    end
    step();
    vectors++;
    if ({bus.i_gnt, bus.mem_ren, bus.mem_wen, busy} !== 4'b1101) begin
      miscompares++;
      $display("FAIL b2b_acc2 got gnt/ren/wen/busy=%b exp=1101", {bus.i_gnt, bus.mem_ren, bus.mem_wen, busy});
    end
    bus.i_req = 1'b0;
    step();
    vectors++;
    if (bus.i_valid !== 1'b1 || bus.i_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_resp2 got valid=%b gnt=%b exp 1 0", bus.i_valid, bus.i_gnt);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    bus.d_req = 1'b1; bus.d_addr = 32'd6;
    bus.i_req = 1'b1; bus.i_addr = 32'd8;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (conflicts !== exp_cnt[k] || (bus.mem_ren & bus.mem_wen) !== 1'b0) begin
        miscompares++;
        $display("FAIL sat_cnt[%0d] got conflicts=%0d ren&wen=%b exp %0d 0",
                 k, conflicts, bus.mem_ren & bus.mem_wen, exp_cnt[k]);
      end
      step();
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd7; bus.d_wdata = 32'hDEAD;
    step();
    vectors++;
    if (bus.d_gnt !== 1'b1 || bus.mem_wen !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_acc got gnt=%b wen=%b exp 1 1", bus.d_gnt, bus.mem_wen);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, bus.d_gnt, bus.mem_wen, bus.mem_addr, bus.mem_din} !== '0) begin
      miscompares++;
      $display("FAIL mid_rst got busy=%b gnt=%b wen=%b addr=%h din=%h exp all 0",
               busy, bus.d_gnt, bus.mem_wen, bus.mem_addr, bus.mem_din);
    end
    idle_inputs();
    step();
    step();
    vectors++;
    if (bus.d_valid !== 1'b0 || written[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_nocommit got valid=%b written=%b exp 0 0", bus.d_valid, written[7]);
    end
    reset = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 32'd7;
    step();
    bus.i_req = 1'b0;
    step();
    vectors++;
    if (bus.i_valid !== 1'b1 || bus.i_rdata !== seed(7) || bus.d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_readback got i_valid=%b rdata=%h d_valid=%b exp 1 %h 0",
               bus.i_valid, bus.i_rdata, bus.d_valid, seed(7));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_both_requests();
    test_back_to_back();
    test_saturation();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
